move_scheduler: RTL and testbench
=================================

// Module: move_scheduler
// PURPOSE
//   Arbitrates move requests from the push-button and PS/2-keyboard front ends and queues them in a small FIFO.
//   Issues each move to the game-logic block as a single-cycle code on its `move` input, with a minimum spacing between moves.
//   Gates issue on the game being in OPERATE; RESET requests bypass the queue.
//   Sits between the input decoders and the game-logic block; move codes use the PARAMS.v macros
//   (`NONE, `UP, `DOWN, `LEFT, `RIGHT, `RESET).
// PARAMETERS
//   FIFO_DEPTH  4   queued moves; power of two, >=2
//   GAP_CYCLES  16  minimum cycles from one issued move to the next; >=1
// PORTS
//   clk         in   1    system clock (100MHz)
//   rst         in   1    synchronous, active-high reset
//   btn_valid   in   1    button requester has a move
//   btn_move    in   3    button move code
//   btn_ready   out  1    button move accepted this cycle (valid&ready)
//   kbd_valid   in   1    keyboard requester has a move
//   kbd_move    in   3    keyboard move code
//   kbd_ready   out  1    keyboard move accepted this cycle
//   game_ready  in   1    game logic is in OPERATE and may take a move
//   move        out  3    move to game logic; `NONE except on issue cycles
//   count       out  clog2(FIFO_DEPTH+1)  FIFO occupancy
//   full        out  1    count == FIFO_DEPTH
// BEHAVIOUR
//   Reset values: move=`NONE, count=0, full=0, FIFO pointers=0, gap counter=0, state=IDLE, rr pointer=button.
//   Arbitration (combinational):
//     - At most one requester is granted per cycle.
//     - If only one requester is valid, it is granted.
//     - If both are valid, the requester not granted last time wins. After reset, button wins.
//     - The rr pointer updates only on an accepted handshake.
//   Ready:
//     - x_ready = grant_x & !rst & (!full | x_move==`RESET).
//     - A requester holds valid and its code until ready; codes must not change while waiting.
//   Accepted `NONE: consumed, not queued.
//   Accepted direction code: pushed at the tail.
//     - No push when full, even if a pop occurs in the same cycle.
//     - A push and a pop in the same cycle leave count unchanged.
//   Accepted `RESET (any FIFO state, ignores game_ready and gap):
//     - Next cycle: move=`RESET for exactly 1 cycle.
//     - FIFO flushed (count=0), gap counter cleared, state IDLE.
//   State machine:
//     IDLE:
//       - If FIFO non-empty & game_ready: pop the head and register move=head for 1 cycle.
//       - Load the gap counter with GAP_CYCLES-1, then go to COOLDOWN (stay IDLE if GAP_CYCLES==1).
//       - If FIFO empty or game_ready=0: move=`NONE.
//     COOLDOWN:
//       - Decrement the gap counter each cycle; move=`NONE.
//       - Return to IDLE when the counter reaches 0.
//     FLUSH:
//       - One cycle, entered on an accepted `RESET; drives move=`RESET.
//       - Exits to IDLE; the next issue waits at least 1 further cycle.
//   Latency:
//     - move is registered.
//     - A move accepted at edge t into an empty FIFO in IDLE with game_ready=1 appears on move during cycle t+1.
//   Spacing:
//     - Consecutive direction issues are at least GAP_CYCLES cycles apart.
//     - The game logic never sees the same code on two consecutive cycles.
//   game_ready low: queue holds and nothing issues; the gap counter still runs down.
//   Ordering: FIFO order = acceptance order; pointers wrap modulo FIFO_DEPTH.
//   Reset mid-operation: rst overrides all; the next cycle shows reset values, and in-flight moves are discarded.
// TESTING
//   1. GAP=16, game_ready=1, btn UP accepted at edge 0 -> move=`UP in cycle 1 only, `NONE cycles 2..16.
//   2. kbd LEFT,LEFT,DOWN back-to-back -> issues at cycles 1, 17, 33; count peaks at 2.
//   3. After reset, btn RIGHT and kbd UP valid together -> btn accepted first, kbd next cycle;
//      issue order RIGHT then UP; third simultaneous request goes to btn.
//   4. game_ready=0, push 4 moves -> count=4, full=1, 5th request ready=0;
//      raise game_ready -> 4 issues 16 cycles apart, then the 5th accepted.
//   5. 3 queued, in COOLDOWN, kbd `RESET -> next cycle move=`RESET, count=0;
//      a new UP accepted afterwards issues without waiting out the old gap.
//   6. rst pulsed during COOLDOWN with count=2 -> next cycle move=`NONE, count=0, full=0;
//      queued moves never issue.

Source files
------------

// File: rtl/move_scheduler.sv
// Move arbiter, queue and paced issuer between the input decoders
// and the game-logic block.
module move_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              btn_valid,
  input  logic [2:0]                        btn_move,
  output logic                              btn_ready,
  input  logic                              kbd_valid,
  input  logic [2:0]                        kbd_move,
  output logic                              kbd_ready,
  input  logic                              game_ready,
  output logic [2:0]                        move,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              full
);

  localparam logic [2:0] MV_NONE  = 3'd0;
  localparam logic [2:0] MV_UP    = 3'd1;
  localparam logic [2:0] MV_DOWN  = 3'd2;
  localparam logic [2:0] MV_LEFT  = 3'd3;
  localparam logic [2:0] MV_RIGHT = 3'd4;
  localparam logic [2:0] MV_RESET = 3'd5;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COOLDOWN,
    S_FLUSH
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [2:0]      move_q, move_d;
  logic            rr_q, rr_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      mem_q [FIFO_DEPTH];

  logic            grant_btn;
  logic            grant_kbd;
  logic            acc;
  logic [2:0]      sel_move;
  logic            is_dir;
  logic            acc_reset;
  logic            push;
  logic            pop;
  logic            flush;
  logic [2:0]      head;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign count = count_q;
  assign move  = move_q;
  assign head  = mem_q[rd_q];

  // rr_q=1 means the keyboard is favoured on the next tie
  always_comb begin
    grant_btn = 1'b0;
    grant_kbd = 1'b0;
    unique case (1'b1)
      (btn_valid && !kbd_valid): grant_btn = 1'b1;
      (!btn_valid && kbd_valid): grant_kbd = 1'b1;
      (btn_valid && kbd_valid): begin
        grant_btn = !rr_q;
        grant_kbd = rr_q;
      end
      default: ;
    endcase
  end

  assign btn_ready = grant_btn & !rst &
                     (!full | (btn_move == MV_RESET));
  assign kbd_ready = grant_kbd & !rst &
                     (!full | (kbd_move == MV_RESET));

  assign acc       = btn_ready | kbd_ready;
  assign sel_move  = btn_ready ? btn_move : kbd_move;
  assign is_dir    = sel_move inside {MV_UP, MV_DOWN,
                                      MV_LEFT, MV_RIGHT};
  assign acc_reset = acc & (sel_move == MV_RESET);
  assign push      = acc & is_dir & !full;

  always_comb begin
    rr_d = rr_q;
    if (btn_ready) begin
      rr_d = 1'b1;
    end else if (kbd_ready) begin
      rr_d = 1'b0;
    end
  end

  // A repeat RESET while one is already on the bus is absorbed
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    move_d  = MV_NONE;
    pop     = 1'b0;
    flush   = 1'b0;
    if (acc_reset) begin
      flush = 1'b1;
      gap_d = '0;
      if (move_q != MV_RESET) begin
        move_d  = MV_RESET;
        state_d = S_FLUSH;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if ((count_q != '0) && game_ready &&
              (head != move_q)) begin
            pop    = 1'b1;
            move_d = head;
            gap_d  = GW'(GAP_CYCLES - 1);
            if (GAP_CYCLES > 1) begin
              state_d = S_COOLDOWN;
            end
          end
        end
        S_COOLDOWN: begin
          if (gap_q <= GW'(1)) begin
            gap_d   = '0;
            state_d = S_IDLE;
          end else begin
            gap_d = gap_q - GW'(1);
          end
        end
        S_FLUSH: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wr_d = wr_q + PW'(1);
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      move_q  <= MV_NONE;
      rr_q    <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      move_q  <= move_d;
      rr_q    <= rr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= sel_move;
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: latency, pacing, arbitration,
// back-pressure, RESET bypass and synchronous reset.
module tb_move_scheduler;

  localparam logic [2:0] NONE  = 3'd0;
  localparam logic [2:0] UP    = 3'd1;
  localparam logic [2:0] DOWN  = 3'd2;
  localparam logic [2:0] LEFT  = 3'd3;
  localparam logic [2:0] RIGHT = 3'd4;
  localparam logic [2:0] RST   = 3'd5;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_valid;
  logic [2:0] btn_move;
  logic       btn_ready;
  logic       kbd_valid;
  logic [2:0] kbd_move;
  logic       kbd_ready;
  logic       game_ready;
  logic [2:0] move;
  logic [2:0] count;
  logic       full;

  int errors = 0;
  int checks = 0;

  move_scheduler #(.FIFO_DEPTH(4), .GAP_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_valid  (btn_valid),
    .btn_move   (btn_move),
    .btn_ready  (btn_ready),
    .kbd_valid  (kbd_valid),
    .kbd_move   (kbd_move),
    .kbd_ready  (kbd_ready),
    .game_ready (game_ready),
    .move       (move),
    .count      (count),
    .full       (full)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn_valid = 1'b0;
    kbd_valid = 1'b0;
    btn_move = NONE;
    kbd_move = NONE;
    game_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    game_ready = 1'b1;
    btn_valid = 1'b1;
    btn_move = UP;
    kbd_valid = 1'b1;
    kbd_move = RST;
    step();
    step();
    checks++;
    if (move !== NONE) begin
      errors++;
      $display("FAIL reset_move got=%0d exp=%0d", move, NONE);
    end
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL reset_count got=%0d exp=0", count);
    end
    checks++;
    if (full !== 1'b0) begin
      errors++;
      $display("FAIL reset_full got=%0b exp=0", full);
    end
    checks++;
    if ({btn_ready, kbd_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=00",
               {btn_ready, kbd_ready});
    end
    btn_valid = 1'b0;
    kbd_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [2:0] exp;
    do_reset();
    game_ready = 1'b1;
    for (int e = 0; e <= 18; e++) begin
      if (e == 0) begin
        btn_valid = 1'b1;
        btn_move = UP;
        #1;
        checks++;
        if (btn_ready !== 1'b1) begin
          errors++;
          $display("FAIL single_ready got=%0b exp=1", btn_ready);
        end
      end else begin
        btn_valid = 1'b0;
      end
      step();
      exp = (e == 1) ? UP : NONE;
      checks++;
      if (move !== exp) begin
        errors++;
        $display("FAIL single_move e=%0d got=%0d exp=%0d",
                 e, move, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp;
    int peak;
    peak = 0;
    do_reset();
    game_ready = 1'b1;
    for (int e = 0; e <= 34; e++) begin
      kbd_valid = (e <= 2);
      kbd_move = (e == 2) ? DOWN : LEFT;
      if (e <= 2) begin
        #1;
        checks++;
        if (kbd_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready e=%0d got=%0b exp=1",
                   e, kbd_ready);
        end
      end
      step();
      if (int'(count) > peak) peak = int'(count);
      exp = (e == 1 || e == 17) ? LEFT :
            (e == 33) ? DOWN : NONE;
      checks++;
      if (move !== exp) begin
        errors++;
        $display("FAIL b2b_move e=%0d got=%0d exp=%0d",
                 e, move, exp);
      end
    end
    checks++;
    if (peak !== 2) begin
      errors++;
      $display("FAIL b2b_peak got=%0d exp=2", peak);
    end
  endtask

  task automatic test_arbitration();
    logic [2:0] exp;
    logic [1:0] exp_rdy;
    do_reset();
    game_ready = 1'b1;
    for (int e = 0; e <= 50; e++) begin
      exp_rdy = 2'b00;
      case (e)
        0: begin
          btn_valid = 1'b1; btn_move = RIGHT;
          kbd_valid = 1'b1; kbd_move = UP;
          exp_rdy = 2'b10;
        end
        1: begin
          btn_valid = 1'b1; btn_move = LEFT;
          exp_rdy = 2'b01;
        end
        2: begin
          kbd_valid = 1'b1; kbd_move = DOWN;
          exp_rdy = 2'b10;
        end
        3: begin
          btn_valid = 1'b0;
          exp_rdy = 2'b01;
        end
        default: begin
          btn_valid = 1'b0;
          kbd_valid = 1'b0;
        end
      endcase
      if (e <= 3) begin
        #1;
        checks++;
        if ({btn_ready, kbd_ready} !== exp_rdy) begin
          errors++;
          $display("FAIL arb_ready e=%0d got=%b exp=%b",
                   e, {btn_ready, kbd_ready}, exp_rdy);
        end
      end
      step();
      exp = (e == 1)  ? RIGHT :
            (e == 17) ? UP :
            (e == 33) ? LEFT :
            (e == 49) ? DOWN : NONE;
      checks++;
      if (move !== exp) begin
        errors++;
        $display("FAIL arb_move e=%0d got=%0d exp=%0d",
                 e, move, exp);
      end
    end
  endtask

  task automatic test_full();
    logic [2:0] exp;
    logic [2:0] seq [4];
    seq[0] = UP; seq[1] = DOWN; seq[2] = LEFT; seq[3] = RIGHT;
    do_reset();
    game_ready = 1'b0;
    for (int e = 0; e <= 70; e++) begin
      if (e <= 3) begin
        btn_valid = 1'b1;
        btn_move = seq[e];
        #1;
        checks++;
        if (btn_ready !== 1'b1) begin
          errors++;
          $display("FAIL full_push e=%0d got=%0b exp=1",
                   e, btn_ready);
        end
      end else if (e == 4) begin
        checks++;
        if ({count, full} !== {3'd4, 1'b1}) begin
          errors++;
          $display("FAIL full_level got=%0d/%0b exp=4/1",
                   count, full);
        end
        btn_move = UP;
        #1;
        checks++;
        if (btn_ready !== 1'b0) begin
          errors++;
          $display("FAIL full_block got=%0b exp=0", btn_ready);
        end
        game_ready = 1'b1;
      end else if (e == 5) begin
        #1;
        checks++;
        if (btn_ready !== 1'b1) begin
          errors++;
          $display("FAIL full_fifth got=%0b exp=1", btn_ready);
        end
      end else begin
        btn_valid = 1'b0;
      end
      step();
      exp = (e == 4)  ? UP :
            (e == 20) ? DOWN :
            (e == 36) ? LEFT :
            (e == 52) ? RIGHT :
            (e == 68) ? UP : NONE;
      checks++;
      if (move !== exp) begin
        errors++;
        $display("FAIL full_move e=%0d got=%0d exp=%0d",
                 e, move, exp);
      end
    end
  endtask

  task automatic test_reset_code();
    logic [2:0] exp;
    logic [2:0] seq [4];
    seq[0] = UP; seq[1] = DOWN; seq[2] = LEFT; seq[3] = RIGHT;
    do_reset();
    game_ready = 1'b1;
    for (int e = 0; e <= 22; e++) begin
      btn_valid = 1'b0;
      kbd_valid = 1'b0;
      if (e <= 3) begin
        kbd_valid = 1'b1;
        kbd_move = seq[e];
      end else if (e == 4) begin
        kbd_valid = 1'b1;
        kbd_move = RST;
        #1;
        checks++;
        if (kbd_ready !== 1'b1) begin
          errors++;
          $display("FAIL rcode_ready got=%0b exp=1", kbd_ready);
        end
      end else if (e == 5) begin
        btn_valid = 1'b1;
        btn_move = UP;
      end
      step();
      exp = (e == 1 || e == 6) ? UP :
            (e == 4) ? RST : NONE;
      checks++;
      if (move !== exp) begin
        errors++;
        $display("FAIL rcode_move e=%0d got=%0d exp=%0d",
                 e, move, exp);
      end
      if (e == 3) begin
        checks++;
        if (count !== 3'd3) begin
          errors++;
          $display("FAIL rcode_queued got=%0d exp=3", count);
        end
      end
      if (e == 4) begin
        checks++;
        if ({count, full} !== 4'b0000) begin
          errors++;
          $display("FAIL rcode_flush got=%0d/%0b exp=0/0",
                   count, full);
        end
      end
      if (e == 5) begin
        checks++;
        if (count !== 3'd1) begin
          errors++;
          $display("FAIL rcode_newpush got=%0d exp=1", count);
        end
      end
    end
  endtask

  task automatic test_rst_midop();
    logic [2:0] exp;
    logic [2:0] seq [3];
    seq[0] = UP; seq[1] = DOWN; seq[2] = LEFT;
    do_reset();
    game_ready = 1'b1;
    for (int e = 0; e <= 44; e++) begin
      btn_valid = (e <= 2);
      if (e <= 2) btn_move = seq[e];
      rst = (e == 4);
      step();
      exp = (e == 1) ? UP : NONE;
      checks++;
      if (move !== exp) begin
        errors++;
        $display("FAIL rmid_move e=%0d got=%0d exp=%0d",
                 e, move, exp);
      end
      if (e == 3) begin
        checks++;
        if (count !== 3'd2) begin
          errors++;
          $display("FAIL rmid_queued got=%0d exp=2", count);
        end
      end
      if (e == 4) begin
        checks++;
        if ({count, full} !== 4'b0000) begin
          errors++;
          $display("FAIL rmid_clear got=%0d/%0b exp=0/0",
                   count, full);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_arbitration();
    test_full();
    test_reset_code();
    test_rst_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
